// File: rtl/power_supervisor_pkg.sv
// Shared definitions for the power supervisor and its holdoff timer.
// Holds the FSM state encoding, the counter widths and the channel-parity helper.
package power_pkg;

  // FSM state encoding. These values are visible on the `state` output.
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RUN     = 3'd1,
    ST_ACK     = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // The holdoff timer covers 1 s at 50 MHz.
  localparam int HOLDOFF_W = 26;

  // Widths of the retry and restart counters.
  localparam int CNT_W = 4;

  // Width and ceiling of the saturating fault log.
  localparam int FAULT_W = 8;
  localparam logic [FAULT_W-1:0] FAULT_MAX = '1;

  // Odd comparator channels watch the upper threshold.
  // A fault on an odd channel is therefore an overvoltage.
  function automatic logic is_overvoltage(input logic [2:0] sel);
    return (sel & 3'b001) != 3'b000;
  endfunction

endpackage

// File: rtl/power_supervisor_if.sv
// Link between the supervisor and the power management monitor.
// The supervisor drives start and ack. The monitor drives error and sel.
interface power_supervisor_if;
  logic       start;
  logic       ack;
  logic       error;
  logic [2:0] sel;

  // Supervisor side.
  modport master (
    output start,
    output ack,
    input  error,
    input  sel
  );

  // Monitor side.
  modport slave (
    input  start,
    input  ack,
    output error,
    output sel
  );
endinterface

// File: rtl/power_supervisor_holdoff_timer.sv
// Power-off dwell timer for the supervisor's auto-restart.
// A load pulse (re)starts the count. `done` pulses for one cycle, timed so that
// the FSM leaves HOLDOFF exactly HOLDOFF_CYCLES edges after the load edge.
module holdoff_timer
  import power_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic done
);

  // The pulse must already be registered in the cycle before the exit edge.
  // It therefore fires when the count reaches HOLDOFF_CYCLES-1.
  localparam logic [HOLDOFF_W-1:0] LAST_COUNT = HOLDOFF_W'(HOLDOFF_CYCLES - 1);
  localparam logic                 ONE_CYCLE  = (HOLDOFF_CYCLES <= 1);

  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;

  // Next count. A load always wins, so re-entry restarts from scratch.
  // A load also discards any pulse left over from an abandoned holdoff.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (load) begin
      cnt_d  = HOLDOFF_W'(1);
      done_d = ONE_CYCLE;
      run_d  = ~ONE_CYCLE;
    end else if (run_q) begin
      if (cnt_q == LAST_COUNT) begin
        done_d = 1'b1;
        run_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + HOLDOFF_W'(1);
      end
    end
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/power_supervisor.sv
// Fault-policy controller for the power management monitor.
// - Overvoltage (odd channel) locks power off until software clears it.
// - Undervoltage (even channel) is acknowledged up to a retry budget.
// - When the budget is used up, power is cycled a bounded number of times.
// - When the restarts are used up, power locks off.
module power_supervisor
  import power_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 50_000_000,
  parameter int unsigned UV_RETRIES     = 3,  // 1..15
  parameter int unsigned RESTART_MAX    = 2   // 0..15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable_req,
  input  logic                 clear_req,
  power_supervisor_if.master   mon,
  output logic [2:0]           state,
  output logic                 locked_out,
  output logic [FAULT_W-1:0]   fault_count,
  output logic [2:0]           last_fault_sel
);

  localparam logic [CNT_W-1:0] UV_LIMIT      = CNT_W'(UV_RETRIES);
  localparam logic [CNT_W-1:0] RESTART_LIMIT = CNT_W'(RESTART_MAX);

  state_e               state_q, state_d;
  logic                 start_q, start_d;
  logic                 ack_q, ack_d;
  logic                 locked_q, locked_d;
  logic [FAULT_W-1:0]   fault_cnt_q, fault_cnt_d;
  logic [2:0]           last_sel_q, last_sel_d;
  logic [CNT_W-1:0]     uv_cnt_q, uv_cnt_d;
  logic [CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]     uv_cnt_inc;
  logic                 timer_load;
  logic                 timer_done;

  assign uv_cnt_inc = uv_cnt_q + CNT_W'(1);

  // Dwell timer for power cycling.
  // It is reloaded on every entry into HOLDOFF.
  holdoff_timer #(
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) u_holdoff_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .done    (timer_done)
  );

  // Next state, counters and outputs.
  // Outputs are decoded from the next state, so they change on the same edge as `state`.
  always_comb begin
    state_d     = state_q;
    fault_cnt_d = fault_cnt_q;
    last_sel_d  = last_sel_q;
    uv_cnt_d    = uv_cnt_q;
    rst_cnt_d   = rst_cnt_q;

    unique case (state_q)
      ST_OFF: begin
        if (enable_req) begin
          state_d   = ST_RUN;
          uv_cnt_d  = '0;
          rst_cnt_d = '0;
        end
      end

      ST_RUN: begin
        // Dropping the power request beats a simultaneous fault.
        // That fault is not logged.
        if (!enable_req) begin
          state_d = ST_OFF;
        end else if (mon.error) begin
          // sel is frozen by the monitor while error is high, so sampling it here is exact.
          fault_cnt_d = (fault_cnt_q == FAULT_MAX) ? fault_cnt_q
                                                   : fault_cnt_q + FAULT_W'(1);
          last_sel_d  = mon.sel;
          if (is_overvoltage(mon.sel)) begin
            state_d = ST_LOCKOUT;
          end else begin
            uv_cnt_d = uv_cnt_inc;
            state_d  = (uv_cnt_inc == UV_LIMIT) ? ST_HOLDOFF : ST_ACK;
          end
        end
      end

      ST_ACK: begin
        // Hold ack until the monitor drops error.
        if (!enable_req) begin
          state_d = ST_OFF;
        end else if (!mon.error) begin
          state_d = ST_RUN;
        end
      end

      ST_HOLDOFF: begin
        if (!enable_req) begin
          state_d = ST_OFF;
        end else if (timer_done) begin
          if (rst_cnt_q == RESTART_LIMIT) begin
            state_d = ST_LOCKOUT;
          end else begin
            rst_cnt_d = rst_cnt_q + CNT_W'(1);
            uv_cnt_d  = '0;
            state_d   = ST_RUN;
          end
        end
      end

      ST_LOCKOUT: begin
        // Only software can leave lockout.
        // The fault log survives the clear.
        if (clear_req) begin
          state_d   = ST_OFF;
          uv_cnt_d  = '0;
          rst_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    start_d    = (state_d == ST_RUN) || (state_d == ST_ACK);
    ack_d      = (state_d == ST_ACK);
    locked_d   = (state_d == ST_LOCKOUT);
    timer_load = (state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF);
  end

  // FSM and output registers.
  // Reset removes power on the next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      locked_q    <= 1'b0;
      fault_cnt_q <= '0;
      last_sel_q  <= '0;
      uv_cnt_q    <= '0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      locked_q    <= locked_d;
      fault_cnt_q <= fault_cnt_d;
      last_sel_q  <= last_sel_d;
      uv_cnt_q    <= uv_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign mon.start      = start_q;
  assign mon.ack        = ack_q;
  assign state          = state_q;
  assign locked_out     = locked_q;
  assign fault_count    = fault_cnt_q;
  assign last_fault_sel = last_sel_q;

endmodule

// File: tb/tb_power_supervisor.sv
// Scoreboard bench for power_supervisor.
// - The driver steps a behavioural model each cycle and queues the expected outputs.
// - An independent monitor pops one entry after each clock edge and compares it.
module tb_power_supervisor;

  localparam int HC   = 20;
  localparam int UVR  = 3;
  localparam int RMAX = 1;

  // Mode numbers as they appear on the state output.
  localparam int M_OFF  = 0;
  localparam int M_RUN  = 1;
  localparam int M_ACK  = 2;
  localparam int M_HOLD = 3;
  localparam int M_LOCK = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable_req = 1'b0;
  logic       clear_req = 1'b0;
  logic [2:0] state;
  logic       locked_out;
  logic [7:0] fault_count;
  logic [2:0] last_fault_sel;

  power_supervisor_if mon_if ();

  power_supervisor #(
    .HOLDOFF_CYCLES (HC),
    .UV_RETRIES     (UVR),
    .RESTART_MAX    (RMAX)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_req     (enable_req),
    .clear_req      (clear_req),
    .mon            (mon_if),
    .state          (state),
    .locked_out     (locked_out),
    .fault_count    (fault_count),
    .last_fault_sel (last_fault_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int start;
    int ack;
    int lk;
    int fc;
    int ls;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: fault bookkeeping and a countdown of remaining holdoff cycles.
  int m_mode = M_OFF;
  int m_uv = 0;
  int m_rs = 0;
  int m_hold = 0;
  int m_fc = 0;
  int m_ls = 0;

  task automatic model_step(input bit rst, input bit en, input bit clr, input bit err, input int s);
    if (!rst) begin
      m_mode = M_OFF; m_uv = 0; m_rs = 0; m_hold = 0; m_fc = 0; m_ls = 0;
    end else begin
      case (m_mode)
        M_OFF:  if (en) begin m_mode = M_RUN; m_uv = 0; m_rs = 0; end
        M_RUN: begin
          if (!en) m_mode = M_OFF;
          else if (err) begin
            if (m_fc < 255) m_fc = m_fc + 1;
            m_ls = s;
            if (s % 2 == 1) m_mode = M_LOCK;
            else begin
              m_uv = m_uv + 1;
              if (m_uv == UVR) begin m_mode = M_HOLD; m_hold = HC; end
              else m_mode = M_ACK;
            end
          end
        end
        M_ACK: begin
          if (!en) m_mode = M_OFF;
          else if (!err) m_mode = M_RUN;
        end
        M_HOLD: begin
          if (!en) m_mode = M_OFF;
          else begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin
              if (m_rs == RMAX) m_mode = M_LOCK;
              else begin m_rs = m_rs + 1; m_uv = 0; m_mode = M_RUN; end
            end
          end
        end
        default: if (clr) begin m_mode = M_OFF; m_uv = 0; m_rs = 0; end
      endcase
    end
  endtask

  // Drive one cycle of inputs, queue the model's post-edge outputs, advance to posedge+4.
  task automatic cyc(input bit rst, input bit en, input bit clr, input bit err, input int s);
    exp_t e;
    reset_n      = rst;
    enable_req   = en;
    clear_req    = clr;
    mon_if.error = err;
    mon_if.sel   = 3'(s);
    model_step(rst, en, clr, err, s);
    e.st    = m_mode;
    e.start = (m_mode == M_RUN || m_mode == M_ACK) ? 1 : 0;
    e.ack   = (m_mode == M_ACK) ? 1 : 0;
    e.lk    = (m_mode == M_LOCK) ? 1 : 0;
    e.fc    = m_fc;
    e.ls    = m_ls;
    exp_q.push_back(e);
    @(posedge clk);
    #4;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(1'b1, en, 1'b0, 1'b0, 0);
  endtask

  // Even-channel fault held for 1+hold cycles, then released by the monitor.
  task automatic uv(input int s, input int hold);
    for (int i = 0; i <= hold; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, s);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, s);
  endtask

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expected record per clock edge, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    int   prev_st;
    prev_st = -1;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("state", int'(state), e.st);
        check("start", int'(mon_if.start), e.start);
        check("ack", int'(mon_if.ack), e.ack);
        check("locked_out", int'(locked_out), e.lk);
        check("fault_count", int'(fault_count), e.fc);
        check("last_fault_sel", int'(last_fault_sel), e.ls);
        if (e.st != prev_st)
          $display("txn t=%0t state %0d -> %0d fault_count=%0d last_sel=%0d",
                   $time, prev_st, e.st, e.fc, e.ls);
        prev_st = e.st;
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic from an emulated monitor.
  initial begin
    bit err;
    int s;
    bit rst, en, clr, mstart;
    mon_if.error = 1'b0;
    mon_if.sel   = 3'd0;

    // Reset and power-on.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(3, 1'b1);

    // Overvoltage lockout; enable toggling ignored; clear returns to OFF then RUN.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
    idle(2, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);   // clear outside lockout is ignored

    // Undervoltage retries, then one holdoff and auto-restart.
    uv(2, 2);
    idle(2, 1'b1);
    uv(4, 2);
    idle(2, 1'b1);
    uv(0, 0);
    idle(HC + 4, 1'b1);

    // Restart budget exhausted: the second holdoff expiry locks out.
    uv(2, 1);
    uv(6, 1);
    uv(0, 0);
    idle(HC + 4, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
    idle(2, 1'b1);

    // Enable drop beats a simultaneous fault.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(2, 1'b1);

    // Reset in the middle of a holdoff.
    uv(2, 1);
    uv(2, 1);
    uv(4, 0);
    idle(8, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(3, 1'b1);

    // Randomized traffic.
    // sel is held steady while error is high.
    // error drops once the fault is acknowledged or power is off.
    err = 1'b0;
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 499) != 0);
      en     = ($urandom_range(0, 59) != 0);
      clr    = ($urandom_range(0, 19) == 0);
      mstart = (m_mode == M_RUN || m_mode == M_ACK);
      if (err) begin
        if (!mstart || (m_mode == M_ACK && $urandom_range(0, 1) == 1)) err = 1'b0;
      end else begin
        s = int'($urandom_range(0, 7));
        if (mstart && $urandom_range(0, 7) == 0) err = 1'b1;
      end
      cyc(rst, en, clr, err, s);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
